// File: rtl/fanin_merge_rr_pkg.sv
// fanin_merge_pkg: shared id-width helper and skid-buffer entry type for fanin_merge_rr.
package fanin_merge_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_ID_W   = 4;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the widest legal configuration; the top slices what it needs.
    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_ID_W-1:0]   id;
    } entry_t;

endpackage

// File: rtl/fanin_merge_rr_arbiter.sv
// rr_arbiter: round-robin grant, first requester at or above ptr with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        int j;
        logic [IW-1:0] jj;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j  = int'(ptr) + k;
            j  = (j >= N) ? j - N : j;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end
endmodule

// File: rtl/fanin_merge_rr.sv
// fanin_merge_rr: round-robin merge of NUM_SRC valid/ready sources into one
// registered output through a 2-entry skid FIFO.
module fanin_merge_rr
    import fanin_merge_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    localparam int IW     = id_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      dst_valid,
    input  logic                      dst_ready,
    output logic [DATA_W-1:0]         dst_data,
    output logic [IW-1:0]             dst_src_id
);
    entry_t        ent_q [2];
    entry_t        ent_d [2];
    entry_t        head;
    entry_t        new_ent;
    logic          rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0] gidx;
    logic          push, pop, wr_idx;

    rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gidx)
    );

    assign head       = ent_q[rd_q];
    assign dst_valid  = cnt_q != 2'd0;
    assign dst_data   = head.data[DATA_W-1:0];
    assign dst_src_id = head.id[IW-1:0];
    assign pop        = dst_valid && dst_ready;
    // A full buffer can still accept when the head leaves this same cycle.
    assign src_ready  = rst ? '0 : (gnt & {NUM_SRC{(cnt_q != 2'd2) || dst_ready}});
    assign push       = |src_ready;
    // When full and popping, the freed slot is the head slot itself.
    assign wr_idx     = rd_q ^ cnt_q[0];

    always_comb begin
        new_ent      = '0;
        new_ent.data = MAX_DATA_W'(src_data[int'(gidx)*DATA_W +: DATA_W]);
        new_ent.id   = MAX_ID_W'(gidx);
        ent_d        = ent_q;
        if (push) ent_d[wr_idx] = new_ent;
        rd_d     = rd_q ^ pop;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        rr_ptr_d = !push ? rr_ptr_q : (int'(gidx) == NUM_SRC - 1) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q    <= '{default: '0};
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
            rr_ptr_q <= '0;
        end else begin
            ent_q    <= ent_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_fanin_merge_rr.sv
// tb_fanin_merge_rr: directed checks of reset, round-robin order, backpressure,
// wrap and mid-stream reset for fanin_merge_rr (NUM_SRC=4, DATA_W=8).
module tb_fanin_merge_rr;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [31:0] src_data;
    logic        dst_valid;
    logic        dst_ready;
    logic [7:0]  dst_data;
    logic [1:0]  dst_src_id;
    int checks = 0;
    int failures = 0;

    fanin_merge_rr #(.NUM_SRC(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dst_data   (dst_data),
        .dst_src_id (dst_src_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        src_valid = 4'b0000;
        dst_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = 4'b1111;
        dst_ready = 1'b1;
        src_data = 32'h13121110;
        tick();
        tick();
        checks++;
        if (dst_valid !== 1'b0) begin failures++; $display("FAIL reset_dst_valid got %b want 0", dst_valid); end
        checks++;
        if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_src_ready got %b want 0000", src_ready); end
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin failures++; $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr_q); end
        checks++;
        if (dst_data !== 8'h00 || dst_src_id !== 2'd0) begin
            failures++; $display("FAIL reset_dst_regs got %h/%0d want 00/0", dst_data, dst_src_id);
        end
        rst = 1'b0;
        src_valid = 4'b0000;
        #1;
        checks++;
        if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_idle_ready got %b want 0000", src_ready); end
    endtask

    task automatic test_single();
        apply_reset();
        src_data = 32'h00A50000;
        src_valid = 4'b0100;
        dst_ready = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got %b want 0100", src_ready); end
        tick();
        src_valid = 4'b0000;
        checks++;
        if (dst_valid !== 1'b1 || dst_data !== 8'hA5 || dst_src_id !== 2'd2) begin
            failures++; $display("FAIL single_out got v=%b d=%h id=%0d want v=1 d=a5 id=2", dst_valid, dst_data, dst_src_id);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd3) begin failures++; $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr_q); end
        tick();
        checks++;
        if (dst_valid !== 1'b0) begin failures++; $display("FAIL single_drain got %b want 0", dst_valid); end
    endtask

    task automatic test_all_valid();
        apply_reset();
        src_data = 32'h13121110;
        src_valid = 4'b1111;
        dst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (src_ready !== (4'b0001 << (c % 4))) begin
                failures++; $display("FAIL all_ready[%0d] got %b want %b", c, src_ready, 4'b0001 << (c % 4));
            end
            tick();
            checks++;
            if (dst_valid !== 1'b1 || dst_src_id !== 2'(c % 4) || dst_data !== 8'(8'h10 + c % 4)) begin
                failures++; $display("FAIL all_out[%0d] got v=%b id=%0d d=%h want id=%0d", c, dst_valid, dst_src_id, dst_data, c % 4);
            end
        end
        src_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        apply_reset();
        src_data = 32'h13121110;
        src_valid = 4'b1111;
        dst_ready = 1'b0;
        #1;
        checks++;
        if (src_ready !== 4'b0001) begin failures++; $display("FAIL bp_ready0 got %b want 0001", src_ready); end
        tick();
        checks++;
        if (src_ready !== 4'b0010) begin failures++; $display("FAIL bp_ready1 got %b want 0010", src_ready); end
        tick();
        checks++;
        if (src_ready !== 4'b0000 || dst_valid !== 1'b1 || dst_src_id !== 2'd0) begin
            failures++; $display("FAIL bp_full got r=%b v=%b id=%0d want r=0000 v=1 id=0", src_ready, dst_valid, dst_src_id);
        end
        tick();
        checks++;
        if (src_ready !== 4'b0000 || dst_src_id !== 2'd0 || dst_data !== 8'h10) begin
            failures++; $display("FAIL bp_hold got r=%b id=%0d d=%h want r=0000 id=0 d=10", src_ready, dst_src_id, dst_data);
        end
        dst_ready = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b0100) begin failures++; $display("FAIL bp_full_pop_ready got %b want 0100", src_ready); end
        tick();
        checks++;
        if (dst_valid !== 1'b1 || dst_src_id !== 2'd1 || dst_data !== 8'h11) begin
            failures++; $display("FAIL bp_drain1 got v=%b id=%0d d=%h want id=1 d=11", dst_valid, dst_src_id, dst_data);
        end
        tick();
        checks++;
        if (dst_valid !== 1'b1 || dst_src_id !== 2'd2 || dst_data !== 8'h12) begin
            failures++; $display("FAIL bp_drain2 got v=%b id=%0d d=%h want id=2 d=12", dst_valid, dst_src_id, dst_data);
        end
        src_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        apply_reset();
        src_data = 32'h33222211;
        src_valid = 4'b0100;
        dst_ready = 1'b1;
        tick();
        src_valid = 4'b1001;
        #1;
        checks++;
        if (src_ready !== 4'b1000) begin failures++; $display("FAIL wrap_ready3 got %b want 1000", src_ready); end
        tick();
        checks++;
        if (dst_src_id !== 2'd3 || dst_data !== 8'h33) begin
            failures++; $display("FAIL wrap_out3 got id=%0d d=%h want id=3 d=33", dst_src_id, dst_data);
        end
        checks++;
        if (src_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ready0 got %b want 0001", src_ready); end
        tick();
        checks++;
        if (dst_src_id !== 2'd0 || dst_data !== 8'h11) begin
            failures++; $display("FAIL wrap_out0 got id=%0d d=%h want id=0 d=11", dst_src_id, dst_data);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd1) begin failures++; $display("FAIL wrap_rr_ptr got %0d want 1", dut.rr_ptr_q); end
        src_valid = 4'b0000;
    endtask

    task automatic test_midreset();
        apply_reset();
        src_data = 32'hDDCCBBAA;
        src_valid = 4'b1111;
        dst_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (dst_valid !== 1'b1 || src_ready !== 4'b0000) begin
            failures++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0000", dst_valid, src_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (src_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got %b want 0000", src_ready); end
        tick();
        rst = 1'b0;
        src_valid = 4'b0000;
        dst_ready = 1'b1;
        checks++;
        if (dst_valid !== 1'b0) begin failures++; $display("FAIL mid_after_rst got %b want 0", dst_valid); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dst_valid !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d] got %b want 0", c, dst_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        src_valid = 4'b0000;
        src_data = '0;
        dst_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
